// File: rtl/vectored_intr_ctrl.sv
// Vectored, fixed-priority interrupt controller with edge latching, locked req/ack and RTI tracking.
// Optional nesting up to NEST_DEPTH is enabled by defining VIC_NEST_EN.
module vectored_intr_ctrl #(
    parameter int                NUM_SRC    = 4,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 8'h01,
    parameter int                NEST_DEPTH = 2,
    localparam int               ID_W       = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               gie_set,
    input  logic               gie_clr,
    input  logic               int_ack,
    input  logic               rti_retire,
    output logic               int_req,
    output logic [ADDR_W-1:0]  int_vec,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_SRC-1:0] in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic               gie,
    output logic [NUM_SRC-1:0] ovf,
    output logic               rti_err
);

`ifdef VIC_NEST_EN
    localparam int unsigned DEPTH    = (NEST_DEPTH > NUM_SRC) ? NUM_SRC : NEST_DEPTH;
    localparam bit          NEST_ON  = 1'b1;
`else
    localparam int unsigned DEPTH    = (NEST_DEPTH > 1) ? 1 : NEST_DEPTH;
    localparam bit          NEST_ON  = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] irq_d;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] rise;
    logic               ack_fire;
    logic [NUM_SRC-1:0] ack_bit;
    logic [NUM_SRC-1:0] svc_low;
    logic [NUM_SRC-1:0] below;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] svc_after_rti;
    int unsigned        svc_cnt;
    logic [ID_W-1:0]    pick_id;
    logic               gie_nxt;

    always_comb begin
        rise     = irq & ~irq_d;
        ack_fire = (state == S_REQ) && int_ack;
        ack_bit  = ack_fire ? (NUM_SRC'(1) << int_id) : '0;

        // Isolate the lowest in-service bit; only strictly lower indices may preempt it.
        svc_low = in_service & (~in_service + NUM_SRC'(1));
        below   = (in_service == '0) ? '1 : (svc_low - NUM_SRC'(1));

        svc_cnt = 0;
        for (int unsigned i = 0; i < NUM_SRC; i++)
            svc_cnt = svc_cnt + 32'(in_service[i]);

        eligible = (gie && (svc_cnt < DEPTH)) ? (pending & mask & below) : '0;

        pick_id = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--)
            if (eligible[i-1]) pick_id = ID_W'(i - 1);

        svc_after_rti = rti_retire ? (in_service & ~svc_low) : in_service;

        // RTI is applied before the ack, so an ack's DI always has the final word.
        gie_nxt = gie;
        if (gie_set && (NEST_ON || (in_service == '0))) gie_nxt = 1'b1;
        if (rti_retire) gie_nxt = 1'b1;
        if (gie_clr)    gie_nxt = 1'b0;
        if (ack_fire)   gie_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            irq_d      <= '0;
            mask       <= '1;
            pending    <= '0;
            ovf        <= '0;
            in_service <= '0;
            gie        <= 1'b0;
            rti_err    <= 1'b0;
            int_req    <= 1'b0;
            int_vec    <= '0;
            int_id     <= '0;
        end else begin
            irq_d      <= irq;
            pending    <= (pending & ~ack_bit) | rise;
            ovf        <= ovf | (rise & pending & ~ack_bit);
            in_service <= svc_after_rti | ack_bit;
            gie        <= gie_nxt;
            rti_err    <= rti_retire && (in_service == '0);
            if (mask_we) mask <= mask_wdata;

            case (state)
                S_IDLE: begin
                    if (eligible != '0) begin
                        int_id  <= pick_id;
                        int_vec <= VEC_BASE + ADDR_W'(pick_id);
                        int_req <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (int_ack) begin
                        int_req <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    int_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vectored_intr_ctrl.sv
// Self-checking bench for vectored_intr_ctrl: directed scenarios then random traffic against a set-based model.
module tb_vectored_intr_ctrl;
    localparam int N = 4;
`ifdef VIC_NEST_EN
    localparam int DEPTH = 2;
    localparam bit NEST  = 1'b1;
`else
    localparam int DEPTH = 1;
    localparam bit NEST  = 1'b0;
`endif

    logic         clk, rst;
    logic [N-1:0] irq, mask_wdata;
    logic         mask_we, gie_set, gie_clr, int_ack, rti_retire;
    logic         int_req, gie, rti_err;
    logic [7:0]   int_vec;
    logic [1:0]   int_id;
    logic [N-1:0] in_service, pending, ovf;

    int total = 0;
    int bad   = 0;

    // Reference model: per-channel flags plus a sorted list of in-service channels.
    bit m_irq_d[N], m_pend[N], m_ovf[N], m_mask[N];
    bit m_gie, m_req, m_err;
    int m_id;
    int svc[$];

    vectored_intr_ctrl #(.NUM_SRC(4), .ADDR_W(8), .VEC_BASE(8'h01), .NEST_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .gie_set(gie_set), .gie_clr(gie_clr), .int_ack(int_ack), .rti_retire(rti_retire),
        .int_req(int_req), .int_vec(int_vec), .int_id(int_id), .in_service(in_service),
        .pending(pending), .gie(gie), .ovf(ovf), .rti_err(rti_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] pack(input bit a[N]);
        logic [N-1:0] v = '0;
        for (int c = 0; c < N; c++) v[c] = a[c];
        return v;
    endfunction

    function automatic logic [N-1:0] svc_vec();
        logic [N-1:0] v = '0;
        foreach (svc[k]) v[svc[k]] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_irq_d[c] = 0; m_pend[c] = 0; m_ovf[c] = 0; m_mask[c] = 1;
        end
        m_gie = 0; m_req = 0; m_err = 0; m_id = 0;
        svc.delete();
    endtask

    task automatic model_step();
        bit ack_now, pre_empty, g, e;
        int lim, pick, pos;
        ack_now   = m_req && int_ack;
        pre_empty = (svc.size() == 0);
        lim  = pre_empty ? N : svc[0];
        pick = -1;
        if (m_gie && svc.size() < DEPTH)
            for (int c = 0; c < lim; c++)
                if (pick < 0 && m_pend[c] && m_mask[c]) pick = c;

        for (int c = 0; c < N; c++) begin
            e = irq[c] && !m_irq_d[c];
            if (e && m_pend[c] && !(ack_now && c == m_id)) m_ovf[c] = 1;
            if (ack_now && c == m_id) m_pend[c] = 0;
            if (e) m_pend[c] = 1;
            m_irq_d[c] = irq[c];
        end

        m_err = rti_retire && pre_empty;
        g = m_gie;
        if (gie_set && (NEST || pre_empty)) g = 1;
        if (rti_retire) begin
            g = 1;
            if (!pre_empty) void'(svc.pop_front());
        end
        if (gie_clr) g = 0;
        if (ack_now) begin
            g = 0;
            pos = 0;
            while (pos < svc.size() && svc[pos] < m_id) pos++;
            svc.insert(pos, m_id);
        end
        m_gie = g;

        if (!m_req) begin
            if (pick >= 0) begin m_req = 1; m_id = pick; end
        end else if (ack_now) m_req = 0;

        if (mask_we) for (int c = 0; c < N; c++) m_mask[c] = mask_wdata[c];
    endtask

    task automatic compare();
        chk("req", int_req, m_req);
        if (m_req) begin
            chk("vec", int_vec, (1 + m_id) % 256);
            chk("id", int_id, m_id);
        end
        chk("pend", pending, pack(m_pend));
        chk("isvc", in_service, svc_vec());
        chk("gie", gie, m_gie);
        chk("ovf", ovf, pack(m_ovf));
        chk("err", rti_err, m_err);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
        mask_we = 0; gie_set = 0; gie_clr = 0; int_ack = 0; rti_retire = 0;
    endtask

    task automatic apply_reset();
        rst = 0; irq = '0; mask_we = 0; mask_wdata = '0;
        gie_set = 0; gie_clr = 0; int_ack = 0; rti_retire = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        chk("rst_mask_req", int_req, 0);
        rst = 1;
    endtask

    initial begin
        apply_reset();

        // Single source: channel 2
        gie_set = 1; step();
        irq = 4'b0100; step();
        chk("t1_noreq_yet", int_req, 0);
        step();
        chk("t1_vec", int_vec, 8'h03);
        chk("t1_id", int_id, 2);
        int_ack = 1; step();
        chk("t1_isvc", in_service, 4'b0100);
        chk("t1_gie", gie, 0);
        rti_retire = 1; step();

        // Two simultaneous sources, priority 1 over 3
        irq = '0; step();
        irq = 4'b1010; step();
        step();
        chk("t2_vec1", int_vec, 8'h02);
        int_ack = 1; step();
        rti_retire = 1; step();
        step();
        chk("t2_vec2", int_vec, 8'h04);
        chk("t2_id2", int_id, 3);

        // Locked vector while a higher-priority edge arrives
        irq = 4'b1011; step();
        chk("t3_lock", int_vec, 8'h04);
        int_ack = 1; step();
        rti_retire = 1; step();
        step();
        chk("t3_next", int_id, 0);
        int_ack = 1; step();
        rti_retire = 1; step();

        // Masked channel pends, overflows, then requests once unmasked
        mask_we = 1; mask_wdata = 4'b1110; step();
        irq = '0; step();
        irq = 4'b0001; step();
        irq = '0; step();
        irq = 4'b0001; step();
        step();
        chk("t5_pend", pending, 4'b0001);
        chk("t5_ovf", ovf, 4'b0001);
        chk("t5_noreq", int_req, 0);
        mask_we = 1; mask_wdata = 4'b1111; step();
        step();
        chk("t5_req", int_req, 1);
        chk("t5_id", int_id, 0);

        // RTI and ack in the same cycle, then RTI with nothing in service
        int_ack = 1; rti_retire = 1; step();
        chk("t6_isvc", in_service, 4'b0001);
        chk("t6_err", rti_err, 1);
        rti_retire = 1; step();
        chk("t6_clr", in_service, 4'b0000);
        rti_retire = 1; step();
        chk("t6_err2", rti_err, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(3) == 0) irq[c] = ~irq[c];
            int_ack    = m_req ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            rti_retire = ($urandom_range(7) == 0);
            gie_set    = ($urandom_range(3) == 0);
            gie_clr    = ($urandom_range(15) == 0);
            mask_we    = ($urandom_range(15) == 0);
            mask_wdata = 4'($urandom);
            step();
        end

        // Asynchronous reset while a request is up
        apply_reset();
        gie_set = 1; step();
        irq = 4'b0010; step();
        step();
        chk("t7_req", int_req, 1);
        #2 rst = 0;
        #1;
        chk("t7_async", int_req, 0);
        chk("t7_pend", pending, 0);
        model_reset();
        @(posedge clk);
        #1;
        compare();
        rst = 1;
        step();
        chk("t7_after", pending, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
